// File: rtl/pitch_shifter_pkg.sv
// pitch_shifter_pkg: shared sample/frame widths, DAC frame constants and serializer states
package pitch_shifter_pkg;
    localparam int SAMPLE_W = 12;
    localparam int DAC_FRAME_W = 16;
    localparam logic [1:0] DAC_PD_NORMAL = 2'b00;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} dac_state_t;
    function automatic logic [DAC_FRAME_W-1:0] dac_frame(input logic [SAMPLE_W-1:0] s);
        return {DAC_PD_NORMAL, 2'b00, s};
    endfunction
endpackage

// File: rtl/sclk_tick_gen.sv
// sclk_tick_gen: one-cycle tick every CLK_DIV enabled cycles, restartable by clr
module sclk_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
    logic [DW-1:0] cnt_q, cnt_d;
    // Tick on terminal count and wrap; clr forces a fresh half-period
    always_comb begin
        tick = en && cnt_q == LAST;
        cnt_d = (clr || tick) ? '0 : en ? cnt_q + DW'(1) : cnt_q;
    end
    // Divider register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/dac_serializer.sv
// dac_serializer: valid/ready sample intake with one-entry hold, SPI DAC frame serializer
module dac_serializer
    import pitch_shifter_pkg::*;
#(
    parameter int N = 12,
    parameter int CLK_DIV = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] sample_in,
    input  logic         sample_valid,
    output logic         sample_ready,
    output logic         dac_sclk,
    output logic         dac_sync_n,
    output logic         dac_din,
    output logic         frame_done
);
    localparam int TW = $clog2(2 * DAC_FRAME_W);
    localparam logic [TW-1:0] LAST_T = TW'(2 * DAC_FRAME_W - 1);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] LAST_G = GW'(GAP_CYCLES - 1);
    dac_state_t state_q, state_d;
    logic [N-1:0] hold_q, hold_d;
    logic hold_full_q, hold_full_d;
    logic [DAC_FRAME_W-1:0] shift_q, shift_d;
    logic sclk_q, sclk_d, sync_n_q, sync_n_d, done_q, done_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic accept, load, tick;
    logic [SAMPLE_W-1:0] just;
    sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk(clk),
        .reset(reset),
        .en(state_q == SHIFT),
        .clr(load),
        .tick(tick)
    );
    // Holding register handshake plus frame FSM: each tick toggles sclk, rising ticks shift
    always_comb begin
        sample_ready = !hold_full_q || state_q == IDLE;
        accept = sample_valid && sample_ready;
        load = state_q == IDLE && hold_full_q;
        hold_d = accept ? sample_in : hold_q;
        hold_full_d = accept || (hold_full_q && !load);
        just = SAMPLE_W'(hold_q) << (SAMPLE_W - N);
        state_d = state_q;
        shift_d = shift_q;
        sclk_d = sclk_q;
        sync_n_d = sync_n_q;
        done_d = 1'b0;
        tcnt_d = tcnt_q;
        gcnt_d = gcnt_q;
        case (state_q)
            IDLE: if (load) begin
                state_d = SHIFT;
                shift_d = dac_frame(just);
                sync_n_d = 1'b0;
                tcnt_d = '0;
            end
            SHIFT: if (tick) begin
                sclk_d = !sclk_q;
                tcnt_d = tcnt_q + TW'(1);
                shift_d = sclk_q ? shift_q : shift_q << 1;
                if (tcnt_q == LAST_T) begin
                    state_d = GAP;
                    sync_n_d = 1'b1;
                    done_d = 1'b1;
                    gcnt_d = '0;
                end
            end
            GAP: begin
                state_d = gcnt_q == LAST_G ? IDLE : GAP;
                gcnt_d = gcnt_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    // State, hold and serial output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q <= '0;
            hold_full_q <= 1'b0;
            shift_q <= '0;
            sclk_q <= 1'b1;
            sync_n_q <= 1'b1;
            done_q <= 1'b0;
            tcnt_q <= '0;
            gcnt_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q <= shift_d;
            sclk_q <= sclk_d;
            sync_n_q <= sync_n_d;
            done_q <= done_d;
            tcnt_q <= tcnt_d;
            gcnt_q <= gcnt_d;
        end
    end
    assign dac_sclk = sclk_q;
    assign dac_sync_n = sync_n_q;
    assign dac_din = shift_q[DAC_FRAME_W-1];
    assign frame_done = done_q;
endmodule

// File: tb/tb_dac_serializer.sv
// tb_dac_serializer: two DUT configurations checked against a frame-level model
module tb_dac_serializer;
    logic clk = 1'b0;
    logic reset;
    logic [1:0] valid = 2'b00;
    logic [11:0] s0 = '0;
    logic [7:0] s1 = '0;
    logic [1:0] ready, sclk, sync_n, din, done;
    int tests = 0, fails = 0, cyc = 0;
    logic [15:0] q0[$], q1[$];
    logic psync[2] = '{1'b1, 1'b1};
    logic psclk[2] = '{1'b1, 1'b1};
    logic inf[2] = '{1'b0, 1'b0};
    logic [15:0] bits[2];
    int nf[2] = '{0, 0};
    int lo[2] = '{0, 0};
    int hi[2] = '{1000, 1000};
    int frames[2] = '{0, 0};
    int per[2] = '{0, 0};
    int lastf[2] = '{0, 0};

    dac_serializer u0 (
        .clk(clk), .reset(reset), .sample_in(s0), .sample_valid(valid[0]),
        .sample_ready(ready[0]), .dac_sclk(sclk[0]), .dac_sync_n(sync_n[0]),
        .dac_din(din[0]), .frame_done(done[0])
    );
    dac_serializer #(.N(8), .CLK_DIV(1), .GAP_CYCLES(1)) u1 (
        .clk(clk), .reset(reset), .sample_in(s1), .sample_valid(valid[1]),
        .sample_ready(ready[1]), .dac_sclk(sclk[1]), .dac_sync_n(sync_n[1]),
        .dac_din(din[1]), .frame_done(done[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame capture on falling sclk, checked against the queue of accepted samples
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (reset) begin
                psync[u] = 1'b1;
                psclk[u] = 1'b1;
                inf[u] = 1'b0;
                hi[u] = 1000;
            end else begin
                chk(u == 0 ? "done0" : "done1", done[u], !psync[u] && sync_n[u]);
                if (psync[u] && !sync_n[u]) begin
                    chk("gap_min", hi[u] >= (u == 0 ? 3 : 2), 1);
                    per[u] = cyc - lastf[u];
                    lastf[u] = cyc;
                    inf[u] = 1'b1;
                    bits[u] = '0;
                    nf[u] = 0;
                    lo[u] = 0;
                end
                if (!sync_n[u]) begin
                    lo[u]++;
                    if (psclk[u] && !sclk[u]) begin
                        bits[u] = {bits[u][14:0], din[u]};
                        nf[u]++;
                    end
                end else begin
                    hi[u] = psync[u] ? hi[u] + 1 : 1;
                    chk("sclk_idle", sclk[u], 1);
                    chk("din_idle", din[u], 0);
                end
                if (!psync[u] && sync_n[u] && inf[u]) begin
                    inf[u] = 1'b0;
                    frames[u]++;
                    chk("falls", nf[u], 16);
                    chk("sync_low", lo[u], u == 0 ? 128 : 32);
                    chk("queue_nonempty", (u == 0 ? q0.size() : q1.size()) != 0, 1);
                    if (u == 0 && q0.size() != 0) chk("frame0", bits[u], q0.pop_front());
                    if (u == 1 && q1.size() != 0) chk("frame1", bits[u], q1.pop_front());
                end
                psync[u] = sync_n[u];
                psclk[u] = sclk[u];
            end
        end
    end

    task automatic drive(input int u, input logic [11:0] v, output int acc);
        valid[u] = 1'b1;
        if (u == 0) s0 = v; else s1 = v[7:0];
        acc = -1;
        for (int i = 0; i < 400 && acc < 0; i++) begin
            @(negedge clk);
            if (ready[u]) begin
                acc = cyc;
                if (u == 0) q0.push_back(16'(v));
                else q1.push_back(16'(v[7:0]) << 4);
            end
            @(posedge clk);
            #1;
        end
        chk("accept", acc >= 0, 1);
    endtask

    task automatic wait_frames(input int u, input int n);
        for (int i = 0; i < 5000 && frames[u] < n; i++) @(posedge clk);
        chk("frame_count", frames[u], n);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        for (int u = 0; u < 2; u++) begin
            chk({tag, "_sclk"}, sclk[u], 1);
            chk({tag, "_sync"}, sync_n[u], 1);
            chk({tag, "_din"}, din[u], 0);
            chk({tag, "_done"}, done[u], 0);
            chk({tag, "_ready"}, ready[u], 1);
        end
    endtask

    initial begin
        int a1, a2, a3, lat, tgt;
        reset = 1'b1;
        #1;
        chk_idle_outputs("reset");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // single sample, latency from idle
        drive(0, 12'hA5C, a1);
        valid[0] = 1'b0;
        for (lat = 1; lat < 20; lat++) begin
            @(negedge clk);
            if (!sync_n[0]) break;
        end
        chk("latency", lat, 2);
        wait_frames(0, 1);
        // back-to-back with valid held high
        drive(0, 12'h000, a1);
        drive(0, 12'hFFF, a2);
        drive(0, 12'h800, a3);
        valid[0] = 1'b0;
        chk("second_accept", a2 - a1, 1);
        wait_frames(0, 3);
        chk("period0_a", per[0], 131);
        wait_frames(0, 4);
        chk("period0_b", per[0], 131);
        chk("gap0", hi[0], 1);
        // random valid with sample_in changing every cycle, stalls included
        for (int i = 0; i < 700; i++) begin
            valid[0] = $urandom_range(0, 3) != 0;
            s0 = 12'($urandom);
            @(negedge clk);
            if (valid[0] && ready[0]) q0.push_back(16'(s0));
            @(posedge clk);
            #1;
        end
        valid[0] = 1'b0;
        tgt = frames[0] + q0.size();
        wait_frames(0, tgt);
        // reset after the 7th falling sclk edge
        drive(0, 12'($urandom), a1);
        valid[0] = 1'b0;
        for (int i = 0; i < 500 && !(inf[0] && nf[0] >= 7); i++) @(posedge clk);
        chk("reach_7th_fall", nf[0], 7);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk_idle_outputs("midreset");
        q0.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        drive(0, 12'h123, a1);
        valid[0] = 1'b0;
        wait_frames(0, frames[0] + 1);
        // narrow, fast configuration
        drive(1, 12'h0C3, a1);
        valid[1] = 1'b0;
        wait_frames(1, 1);
        drive(1, 12'($urandom), a1);
        drive(1, 12'($urandom), a2);
        valid[1] = 1'b0;
        wait_frames(1, 3);
        chk("period1", per[1], 34);
        chk("queues_empty", q0.size() + q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
